bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Multi-digit BCD down-counter with an internal tick prescaler and run/pause control. It is the countdown counterpart to the up-counting BCD stopwatch chain. It is loaded with a BCD preset, decrements one count per tick while running, and flags expiry at 0. Its count output feeds the SevenSeg digit decoders directly, one nibble per HEX display.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
CLK_DIV, 50000, clk cycles per decrement tick (50 MHz gives 1 kHz, i.e. 1 ms resolution); must be >= 2.

Ports:
clk  input  1  system clock, rising-edge.
clear_  input  1  asynchronous active-low reset.
load_val  input  4*DIGITS  BCD preset; nibble 0 is the least significant digit.
load  input  1  level-sampled each cycle; loads load_val.
start  input  1  level-sampled; starts or resumes counting.
pause  input  1  level-sampled; suspends counting.
count  output  4*DIGITS  current BCD value, registered.
running  output  1  high while in RUN.
done  output  1  high while in DONE.
expired  output  1  one-cycle pulse on the cycle done first rises.

Behaviour:
- Reset (clear_ low, async): state IDLE; count=0; stored preset=0; prescaler=0; running=0; done=0; expired=0.
- States: IDLE, RUN, PAUSED, DONE. running = (state==RUN); done = (state==DONE).
- Load:
  - Accepted in IDLE, PAUSED, DONE. Ignored in RUN.
  - Sets count and the stored preset to load_val, with every nibble >9 clamped to 9.
  - Clears the prescaler.
  - Next state is IDLE.
- Start from IDLE, PAUSED or DONE:
  - If count != 0, go to RUN.
  - If count == 0, go to DONE and pulse expired in that same transition cycle.
- Start from IDLE or DONE clears the prescaler. Start from PAUSED keeps the prescaler value.
- Priority within one cycle: load > pause > start. Load and start together load only; the timer stays in IDLE.
- RUN:
  - The prescaler counts 0..CLK_DIV-1 and the tick fires when it is at CLK_DIV-1, then wraps to 0.
  - The first decrement occurs CLK_DIV cycles after entering RUN from IDLE.
  - On a tick, count decrements in BCD. A digit at 0 wraps to 9 and borrows from the next digit.
  - The decremented value is registered on the tick edge.
  - If the new value is all-zero: state goes to DONE, done=1, and expired=1 for exactly that cycle.
- Pause in RUN goes to PAUSED. Prescaler and count hold. Pause in other states is ignored.
- DONE: count holds at 0 until load or reset.
- Start in RUN is ignored.
- Reset mid-count: all state is lost immediately (async) and the timer returns to the IDLE reset values.
- No binary intermediate: count is BCD-valid (every nibble 0..9) at all times after reset.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined:
  - On expiry the timer reloads the stored preset instead of entering DONE.
  - It remains in RUN with the prescaler cleared; expired pulses once per period.
  - done stays 0 while auto-reloading.
  - If the stored preset is 0, the behaviour is identical to the undefined case (enter DONE).
- Undefined: the timer enters DONE on expiry as described above; no reload logic is synthesized.

Test Plan:
1. DIGITS=4, CLK_DIV=4; load 0x0012, start -> count 0x0011 after 4 cycles, 0x0010 after 8; 0x0000 after 48 cycles, with done=1 and a single-cycle expired pulse.
2. Borrow chain: load 0x1000, start -> after the first tick count=0x0999; load 0x09A5 -> count=0x0995 (nibble A clamped to 9).
3. Pause/resume: load 0x0005, start, pause after 6 cycles -> count holds 0x0004 for 20 cycles; start -> next decrement to 0x0003 after exactly 2 cycles (prescaler preserved).
4. Priority: in IDLE assert load=1, start=1 with 0x0003 -> count=0x0003, state IDLE, running=0. In RUN assert load with 0x0009 -> ignored. Pause+start together in RUN -> PAUSED.
5. Zero start and reset: load 0x0000, start -> done=1 and expired pulse on the next edge. Drop clear_ asynchronously mid-run -> count=0, running=0, done=0 with no clk edge.
6. AUTO_RELOAD_EN defined: load 0x0002, start -> expired pulses every 8 cycles; count sequence 0x0001, 0x0002 (reloaded), 0x0001, …; done stays 0.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with tick prescaler and run/pause/done control.
// Define AUTO_RELOAD_EN to reload the stored preset on expiry instead of stopping.
module bcd_countdown_timer #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  clear_,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);
    localparam int W  = 4*DIGITS;
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV-1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t          state, state_n;
    logic [W-1:0]    count_n, dec_val;
    logic [PW-1:0]   presc, presc_n;
    logic            expired_n, tick;
`ifdef AUTO_RELOAD_EN
    logic [W-1:0]    preset, preset_n;
`endif

    // Any nibble above 9 saturates to 9 so the count is always BCD-valid.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = v[i*4 +: 4];
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            state   <= IDLE;
            count   <= '0;
            presc   <= '0;
            expired <= 1'b0;
`ifdef AUTO_RELOAD_EN
            preset  <= '0;
`endif
        end else begin
            state   <= state_n;
            count   <= count_n;
            presc   <= presc_n;
            expired <= expired_n;
`ifdef AUTO_RELOAD_EN
            preset  <= preset_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        presc_n   = presc;
        expired_n = 1'b0;
        tick      = (presc == PRESC_MAX);
        dec_val   = bcd_dec(count);
`ifdef AUTO_RELOAD_EN
        preset_n  = preset;
`endif
        // Load is only honoured outside RUN; in RUN, pause gets the next look.
        if (load && state != RUN) begin
            count_n = bcd_clamp(load_val);
            presc_n = '0;
            state_n = IDLE;
`ifdef AUTO_RELOAD_EN
            preset_n = bcd_clamp(load_val);
`endif
        end else if (pause && state == RUN) begin
            state_n = PAUSED;
        end else if (start && state != RUN) begin
            if (state != PAUSED)
                presc_n = '0;
            if (count != '0) begin
                state_n = RUN;
            end else begin
                state_n   = DONE;
                expired_n = 1'b1;
            end
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                count_n = dec_val;
                if (dec_val == '0) begin
                    expired_n = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (preset != '0)
                        count_n = preset;
                    else
                        state_n = DONE;
`else
                    state_n = DONE;
`endif
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    always_comb begin
        running = (state == RUN);
        done    = (state == DONE);
    end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: decimal-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_bcd_countdown_timer;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        clear_ = 1'b1;
    logic [15:0] load_val = '0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [15:0] count;
    logic        running, done, expired;

    int n_cmp = 0;
    int n_err = 0;

    bcd_countdown_timer #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .clear_(clear_), .load_val(load_val), .load(load),
        .start(start), .pause(pause), .count(count), .running(running),
        .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count kept as a plain decimal integer.
    int m_val = 0, m_preset = 0, m_div = 0;
    int m_mode = 0;  // 0 idle, 1 run, 2 paused, 3 done
    bit m_exp = 0;

    function automatic int to_dec(input logic [15:0] b);
        int v, d;
        logic [15:0] t;
        t = b;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(t[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            m_val = 0; m_preset = 0; m_div = 0; m_mode = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (load && m_mode != 1) begin
                m_val = to_dec(load_val); m_preset = m_val; m_div = 0; m_mode = 0;
            end else if (pause && m_mode == 1) begin
                m_mode = 2;
            end else if (start && m_mode != 1) begin
                if (m_mode != 2) m_div = 0;
                if (m_val != 0) m_mode = 1;
                else begin m_mode = 3; m_exp = 1; end
            end else if (m_mode == 1) begin
                if (m_div == CLK_DIV - 1) begin
                    m_div = 0;
                    m_val = m_val - 1;
                    if (m_val == 0) begin
                        m_exp = 1;
`ifdef AUTO_RELOAD_EN
                        if (m_preset != 0) m_val = m_preset;
                        else m_mode = 3;
`else
                        m_mode = 3;
`endif
                    end
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
    end

    function automatic bit bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < 4; i++)
            if (t[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("model_count", 32'(count), 32'(to_bcd(m_val)));
        check("model_running", 32'(running), 32'(m_mode == 1));
        check("model_done", 32'(done), 32'(m_mode == 3));
        check("model_expired", 32'(expired), 32'(m_exp));
        check("bcd_valid", 32'(bcd_ok(count)), 32'd1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] v, input logic l, input logic s, input logic p);
        load_val = v; load = l; start = s; pause = p;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        #1 clear_ = 1'b0;
        cyc(2);
        check("reset_count", 32'(count), 32'h0);
        check("reset_flags", {29'd0, running, done, expired}, 32'h0);
        clear_ = 1'b1;
        cyc(1);

        // Basic countdown from 12
        drive(16'h0012, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        cyc(4);  check("t1_after4", 32'(count), 32'h0011);
        cyc(4);  check("t1_after8", 32'(count), 32'h0010);
        cyc(40); check("t1_zero", 32'(count), 32'h0000);
        check("t1_done_exp", {30'd0, done, expired}, 32'h3);
        cyc(1);  check("t1_exp_once", {30'd0, done, expired}, 32'h2);

        // Borrow chain and clamp
        drive(16'h1000, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        cyc(4);  check("t2_borrow", 32'(count), 32'h0999);
        drive(16'h0000, 0, 0, 1);
        drive(16'h09A5, 1, 0, 0);
        check("t2_clamp", 32'(count), 32'h0995);

        // Pause keeps the prescaler phase
        drive(16'h0005, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        cyc(6);
        drive(16'h0000, 0, 0, 1);
        cyc(19); check("t3_hold", 32'(count), 32'h0004);
        check("t3_paused", 32'(running), 32'h0);
        drive(16'h0000, 0, 1, 0);
        cyc(1);  check("t3_not_yet", 32'(count), 32'h0004);
        cyc(1);  check("t3_resume_tick", 32'(count), 32'h0003);
        drive(16'h0000, 0, 0, 1);

        // Priority
        drive(16'h0003, 1, 1, 0);
        check("t4_load_start", 32'(count), 32'h0003);
        check("t4_idle", {30'd0, running, done}, 32'h0);
        drive(16'h0000, 0, 1, 0);
        drive(16'h0009, 1, 0, 0);
        check("t4_load_in_run", 32'(count), 32'h0003);
        check("t4_still_run", 32'(running), 32'h1);
        drive(16'h0000, 0, 1, 1);
        check("t4_pause_wins", {30'd0, running, done}, 32'h0);

        // Zero start, then asynchronous reset mid-run
        drive(16'h0000, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        check("t5_zero_start", {30'd0, done, expired}, 32'h3);
        cyc(1);  check("t5_exp_drop", 32'(expired), 32'h0);
        drive(16'h0007, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        cyc(5);
        #2 clear_ = 1'b0;
        #1 check("t5_async_count", 32'(count), 32'h0);
        check("t5_async_flags", {29'd0, running, done, expired}, 32'h0);
        @(negedge clk);
        clear_ = 1'b1;
        cyc(1);

`ifdef AUTO_RELOAD_EN
        drive(16'h0002, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        cyc(4);  check("t6_c1", 32'(count), 32'h0001);
        cyc(4);  check("t6_reload", 32'(count), 32'h0002);
        check("t6_exp", {30'd0, done, expired}, 32'h1);
        cyc(4);  check("t6_c1b", 32'(count), 32'h0001);
        cyc(4);  check("t6_exp2", {30'd0, done, expired}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
